// File: rtl/upsample_line2x_pkg.sv
// Shared types and helpers for the 2x nearest-neighbour line upsampler.
package upsample_line2x_pkg;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_REPLAY = 1'b1
  } state_t;

  // Index width for an n-entry line, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsample_linebuf.sv
// One-line pixel store: W x M registers, single write port, asynchronous read.
module upsample_linebuf #(
  parameter int M  = 16,
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [M-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [M-1:0]  rdata
);

  logic [M-1:0] mem [W];

  for (genvar i = 0; i < W; i++) begin : g_ent
    always_ff @(posedge clk) begin
      if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < W; i++) begin
      if (raddr == AW'(i)) rdata = mem[i];
    end
  end

endmodule

// File: rtl/upsample_line2x.sv
// 2x nearest-neighbour upsampler: each pixel emitted twice, each line replayed once.
module upsample_line2x
  import upsample_line2x_pkg::*;
#(
  parameter int M = 16,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         Rst_n,
  input  logic [M-1:0] din,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [M-1:0] dout,
  output logic         valid_out,
  input  logic         ready_in,
  output logic         eol_out
);

  localparam int            AW   = idx_w(W);
  localparam logic [AW-1:0] LAST = AW'(W - 1);

  state_t         state, state_nx;
  logic           run, hold_vld, rep, last_q;
  logic [AW-1:0]  col, rcol;
  logic [M-1:0]   buf_rd;
  logic           drain, drain2, line_done, accept, load_buf;

  upsample_linebuf #(.M(M), .W(W), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (col),
    .wdata (din),
    .raddr (rcol),
    .rdata (buf_rd)
  );

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_FILL;
    else        state <= state_nx;
  end

  always_comb begin
    drain     = hold_vld & ready_in;
    drain2    = drain & rep;
    line_done = drain2 & last_q;
    ready_out = 1'b0;
    load_buf  = 1'b0;
    state_nx  = state;
    case (state)
      S_FILL: begin
        // Once the last pixel of a line is held, stop accepting until replay ends.
        ready_out = run & (!hold_vld | (rep & ready_in)) & !(hold_vld & last_q);
        if (line_done) state_nx = S_REPLAY;
      end
      S_REPLAY: begin
        if (line_done) begin
          state_nx  = S_FILL;
          ready_out = run;
        end else begin
          load_buf = !hold_vld | drain2;
        end
      end
      default: ;
    endcase
    accept = valid_in & ready_out;
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      run      <= 1'b0;
      hold_vld <= 1'b0;
      rep      <= 1'b0;
      last_q   <= 1'b0;
      dout     <= '0;
      col      <= '0;
      rcol     <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        dout     <= din;
        hold_vld <= 1'b1;
        rep      <= 1'b0;
        last_q   <= (col == LAST);
        col      <= (col == LAST) ? '0 : col + 1'b1;
      end else if (load_buf) begin
        dout     <= buf_rd;
        hold_vld <= 1'b1;
        rep      <= 1'b0;
        last_q   <= (rcol == LAST);
        rcol     <= (rcol == LAST) ? '0 : rcol + 1'b1;
      end else if (drain) begin
        if (rep) hold_vld <= 1'b0;
        else     rep      <= 1'b1;
      end
      if (state == S_FILL && line_done) begin
        rcol <= '0;
        col  <= '0;
      end
    end
  end

  assign valid_out = hold_vld;
  assign eol_out   = hold_vld & rep & last_q;

endmodule
